sccb_slave: RTL and testbench

- SCCB responder (camera-side target) for the team's SCCB master; decodes 3-phase write and 2-phase read transactions on sclk/sio.
- Oversamples sclk and sio in the clk domain. Presents a simple register-access port to a parent register file.
- Drives sio only during read-data bits, plus don't-care bits when the optional ACK is enabled.

---
 rtl/sccb_pkg.sv | 34 +++
 rtl/sccb_sync_edge.sv | 61 ++++++
 rtl/sccb_slave.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sccb_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
// Shared types and constants for the SCCB responder and its helpers.
//   sccb_state_e  : responder FSM state encoding
//   SCCB_WR_ID    : default device write ID
//   SCCB_RD_ID    : matching read ID (write ID with LSB set)
//   BIT_CNT_W     : width of the per-byte bit counter
//   BIT_TOP       : bit counter start value (MSB first)
//   BIT_ONE       : bit counter decrement step
// -----------------------------------------------------------------------------
package sccb_pkg;

  localparam int BIT_CNT_W = 3;

  localparam logic [BIT_CNT_W-1:0] BIT_TOP = '1;
  localparam logic [BIT_CNT_W-1:0] BIT_ONE = 1;

  localparam logic [7:0] SCCB_WR_ID = 8'h42;
  localparam logic [7:0] SCCB_RD_ID = SCCB_WR_ID | 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_X,
    ST_SUB,
    ST_SUB_X,
    ST_WDATA,
    ST_WDATA_X,
    ST_RDATA,
    ST_RD_NA,
    ST_WAIT_STOP
  } sccb_state_e;

endpackage

// File: rtl/sccb_sync_edge.sv
// -----------------------------------------------------------------------------
// sccb_sync_edge
// Synchronizes sclk and sio into the clk domain and decodes bus events.
// Event outputs are combinational from registered signals, so a pin change
// becomes visible to a registered consumer SYNC_STAGES+1 clk later.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sclk        : raw SCCB clock
//   sio_din     : raw SCCB data
//   sio_s       : synchronized data (sample value for RISE)
//   start_evt   : sio falling while sclk high
//   stop_evt    : sio rising while sclk high
//   rise_evt    : sclk rising edge
//   fall_evt    : sclk falling edge
// Parameters:
//   SYNC_STAGES : synchronizer depth, 2 or more
// -----------------------------------------------------------------------------
module sccb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic sio_din,
  output logic sio_s,
  output logic start_evt,
  output logic stop_evt,
  output logic rise_evt,
  output logic fall_evt
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sio_sync;
  logic                   sclk_s;
  logic                   sclk_d;
  logic                   sio_d;

  // Preset to 1 so an idle bus (both lines high) produces no events after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      sio_sync  <= '1;
      sclk_d    <= 1'b1;
      sio_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sio_sync  <= {sio_sync[SYNC_STAGES-2:0], sio_din};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      sio_d     <= sio_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sio_s  = sio_sync[SYNC_STAGES-1];

  assign start_evt = sclk_s & sclk_d & sio_d & ~sio_s;
  assign stop_evt  = sclk_s & sclk_d & ~sio_d & sio_s;
  assign rise_evt  = sclk_s & ~sclk_d;
  assign fall_evt  = ~sclk_s & sclk_d;

endmodule

// File: rtl/sccb_slave.sv
// -----------------------------------------------------------------------------
// sccb_slave
// SCCB responder: decodes 3-phase writes and 2-phase reads and presents a
// simple register-access port to a parent register file.
// Ports:
//   clk, rst_n  : system clock (>= 8x sclk), asynchronous active-low reset
//   sclk        : SCCB clock from master
//   sio_din     : SCCB data from pad
//   sio_out     : data driven to pad
//   sio_out_en  : pad output enable, 1 = drive
//   reg_addr    : latched sub-address (no auto-increment)
//   reg_wdata   : write data
//   reg_wr_en   : 1-cycle write strobe
//   reg_rd_en   : 1-cycle read request
//   reg_rdata   : read data, valid 1 clk after reg_rd_en
//   busy        : high from START to STOP
//   proto_err   : 1-cycle pulse on malformed transaction
// Parameters:
//   DEV_ID      : write ID byte; read ID is DEV_ID | 1
//   SYNC_STAGES : input synchronizer depth
// Build option:
//   SCCB_ACK_EN : when defined, drive 0 during the X bit of each addressed
//                 phase (I2C-style ACK); otherwise X bits are never driven.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | bus free, waiting for START
// ID         | shifting in the ID byte
// ID_X       | ID X bit; read flag waits here to start driving data
// SUB        | shifting in the sub-address
// SUB_X      | sub-address X bit
// WDATA      | shifting in write data (STOP with no bits = read phase 1)
// WDATA_X    | write data X bit
// RDATA      | driving read data, one bit per FALL
// RD_NA      | sio released, master NA bit
// WAIT_STOP  | ignoring bits until STOP
// -----------------------------------------------------------------------------
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_WR_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sio_din,
  output logic       sio_out,
  output logic       sio_out_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       proto_err
);

`ifdef SCCB_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  localparam logic [7:0] WR_ID = DEV_ID;
  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  logic sio_s;
  logic start_evt;
  logic stop_evt;
  logic rise_evt;
  logic fall_evt;

  sccb_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sio_din   (sio_din),
    .sio_s     (sio_s),
    .start_evt (start_evt),
    .stop_evt  (stop_evt),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt)
  );

  sccb_state_e          state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shift_reg;
  logic                 rd_flag;   // ID matched the read ID
  logic                 x_seen;    // read-flag ID_X: X-bit RISE already seen
  logic                 hi_bit;    // a bit was sampled in the current sclk-high phase
  logic                 bit_done;  // RDATA: bit 0 has been clocked out
  logic                 rd_ld;     // reg_rdata is valid this cycle
  logic [7:0]           byte_in;
  logic                 stop_is_err;

  assign byte_in = {shift_reg[6:0], sio_s};

  // The master's STOP sequence raises sclk with sio low before releasing sio,
  // so that last rise is not a real data bit. A byte phase holding only that
  // one bit counts as empty when judging whether the STOP was malformed.
  always_comb begin
    stop_is_err = 1'b0;
    case (state)
      ST_ID, ST_RDATA: stop_is_err = 1'b1;
      ST_SUB, ST_WDATA:
        stop_is_err = !((bit_cnt == BIT_TOP) ||
                        ((bit_cnt == (BIT_TOP - BIT_ONE)) && hi_bit));
      default: stop_is_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= BIT_TOP;
      shift_reg  <= '0;
      rd_flag    <= 1'b0;
      x_seen     <= 1'b0;
      hi_bit     <= 1'b0;
      bit_done   <= 1'b0;
      rd_ld      <= 1'b0;
      sio_out    <= 1'b1;
      sio_out_en <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      proto_err <= 1'b0;

      // Parent register file answers one clk after the request.
      rd_ld <= reg_rd_en;
      if (rd_ld) begin
        shift_reg <= reg_rdata;
      end

      if (start_evt) begin
        state      <= ST_ID;
        bit_cnt    <= BIT_TOP;
        rd_flag    <= 1'b0;
        x_seen     <= 1'b0;
        hi_bit     <= 1'b0;
        bit_done   <= 1'b0;
        busy       <= 1'b1;
        sio_out    <= 1'b1;
        sio_out_en <= 1'b0;
      end else if (stop_evt) begin
        proto_err  <= stop_is_err;
        state      <= ST_IDLE;
        bit_cnt    <= BIT_TOP;
        rd_flag    <= 1'b0;
        x_seen     <= 1'b0;
        hi_bit     <= 1'b0;
        bit_done   <= 1'b0;
        busy       <= 1'b0;
        sio_out    <= 1'b1;
        sio_out_en <= 1'b0;
      end else if (rise_evt) begin
        case (state)
          ST_ID: begin
            shift_reg <= byte_in;
            hi_bit    <= 1'b1;
            if (bit_cnt == '0) begin
              bit_cnt <= BIT_TOP;
              if (byte_in == WR_ID) begin
                state   <= ST_ID_X;
                rd_flag <= 1'b0;
              end else if (byte_in == RD_ID) begin
                state     <= ST_ID_X;
                rd_flag   <= 1'b1;
                reg_rd_en <= 1'b1;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt - BIT_ONE;
            end
          end
          ST_ID_X: begin
            if (rd_flag) begin
              x_seen <= 1'b1;
            end else begin
              state <= ST_SUB;
            end
          end
          ST_SUB: begin
            shift_reg <= byte_in;
            hi_bit    <= 1'b1;
            if (bit_cnt == '0) begin
              bit_cnt  <= BIT_TOP;
              reg_addr <= byte_in;
              state    <= ST_SUB_X;
            end else begin
              bit_cnt <= bit_cnt - BIT_ONE;
            end
          end
          ST_SUB_X: state <= ST_WDATA;
          ST_WDATA: begin
            shift_reg <= byte_in;
            hi_bit    <= 1'b1;
            if (bit_cnt == '0) begin
              bit_cnt   <= BIT_TOP;
              reg_wdata <= byte_in;
              reg_wr_en <= 1'b1;
              state     <= ST_WDATA_X;
            end else begin
              bit_cnt <= bit_cnt - BIT_ONE;
            end
          end
          ST_WDATA_X: state <= ST_WAIT_STOP;
          ST_RDATA: begin
            if (bit_cnt == '0) begin
              bit_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - BIT_ONE;
            end
          end
          ST_RD_NA: state <= ST_WAIT_STOP;
          default: ;
        endcase
      end else if (fall_evt) begin
        hi_bit <= 1'b0;
        case (state)
          ST_ID_X: begin
            if (rd_flag && x_seen) begin
              sio_out    <= shift_reg[7];
              sio_out_en <= 1'b1;
              bit_cnt    <= BIT_TOP;
              bit_done   <= 1'b0;
              state      <= ST_RDATA;
            end else if (ACK_EN) begin
              sio_out    <= 1'b0;
              sio_out_en <= 1'b1;
            end
          end
          ST_SUB_X, ST_WDATA_X: begin
            if (ACK_EN) begin
              sio_out    <= 1'b0;
              sio_out_en <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (bit_done) begin
              sio_out    <= 1'b1;
              sio_out_en <= 1'b0;
              state      <= ST_RD_NA;
            end else begin
              // bit_cnt already stepped on the previous RISE
              sio_out <= shift_reg[bit_cnt];
            end
          end
          default: begin
            // First FALL after an X bit ends any ACK drive
            sio_out    <= 1'b1;
            sio_out_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// -----------------------------------------------------------------------------
// tb_sccb_slave
// Drives SCCB transactions as a master (400-clk sclk period) and scores the
// responder's strobes, error pulses and read bytes against a queue of expected
// events filled by the stimulus.
// -----------------------------------------------------------------------------
module tb_sccb_slave;

`ifdef SCCB_ACK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  localparam int Q = 100;  // quarter sclk period in clk cycles

  localparam int EV_WR    = 1;
  localparam int EV_RD    = 2;
  localparam int EV_ERR   = 3;
  localparam int EV_RBYTE = 4;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       m_sio;
  logic       sio_bus;
  logic       sio_out;
  logic       sio_out_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       proto_err;

  // Open-drain style bus: either side can pull low.
  assign sio_bus = m_sio & (sio_out_en ? sio_out : 1'b1);

  sccb_slave #(
    .DEV_ID      (8'h42),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sio_din    (sio_bus),
    .sio_out    (sio_out),
    .sio_out_en (sio_out_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Parent register file stand-in: registered read, one clk latency.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= (reg_addr == 8'h3A) ? 8'h5C : 8'hE1;
  end

  typedef struct {
    int kind;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_cnt   = 0;
  logic smp_en;
  logic [7:0] obs_rbyte;
  event rbyte_ev;

  function automatic void push(input int k, input int d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic pop_check(input int kind, input int val, input string nm);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event, got kind %0d data %0h, expected none", nm, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != val) begin
        n_fail++;
        $display("FAIL %s: got kind %0d data %0h, expected kind %0d data %0h",
                 nm, kind, val, e.kind, e.data);
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors
  initial begin
    forever begin
      @(negedge clk);
      if (reg_wr_en) pop_check(EV_WR, int'({reg_addr, reg_wdata}), "wr_strobe");
      if (reg_rd_en) pop_check(EV_RD, int'(reg_addr), "rd_strobe");
      if (proto_err) pop_check(EV_ERR, 0, "proto_err");
    end
  end

  initial begin
    forever begin
      @(rbyte_ev);
      pop_check(EV_RBYTE, int'(obs_rbyte), "rd_byte");
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sio_out_en) en_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, expected test completion");
    $fatal(1, "timeout");
  end

  // ---------------- master bus tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sio = 1'b1; sclk = 1'b1; wait_clk(Q);
    m_sio = 1'b0; wait_clk(2 * Q);
    sclk  = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sio = 1'b0; wait_clk(Q);
    sclk  = 1'b1; wait_clk(2 * Q);
    m_sio = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic put_bit(input logic b);
    m_sio = b;    wait_clk(Q);
    sclk  = 1'b1; wait_clk(2 * Q);
    sclk  = 1'b0; wait_clk(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sio = 1'b1; wait_clk(Q);
    sclk  = 1'b1; wait_clk(Q);
    b      = sio_bus;
    smp_en = sio_out_en;
    wait_clk(Q);
    sclk  = 1'b0; wait_clk(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, input bit addressed);
    logic x;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(x);
    check($sformatf("x_bit_after_%02h", v), int'(x), (ACK_ON && addressed) ? 0 : 1);
  endtask

  task automatic get_byte(input int nbits, output logic [7:0] v);
    logic b;
    v = '0;
    for (int i = 0; i < nbits; i++) begin
      get_bit(b);
      v = {v[6:0], b};
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         c0;
    logic [7:0] rb;
    logic       b;

    rst_n = 1'b0; sclk = 1'b1; m_sio = 1'b1; smp_en = 1'b0;
    wait_clk(5);
    check("rst_sio_out",    int'(sio_out),    1);
    check("rst_sio_out_en", int'(sio_out_en), 0);
    check("rst_reg_addr",   int'(reg_addr),   0);
    check("rst_reg_wdata",  int'(reg_wdata),  0);
    check("rst_reg_wr_en",  int'(reg_wr_en),  0);
    check("rst_reg_rd_en",  int'(reg_rd_en),  0);
    check("rst_busy",       int'(busy),       0);
    check("rst_proto_err",  int'(proto_err),  0);
    rst_n = 1'b1;
    wait_clk(10);

    // 3-phase write 0x42 0x12 0xA5
    c0 = en_cnt;
    bus_start();
    check("busy_after_start", int'(busy), 1);
    put_byte(8'h42, 1'b1);
    put_byte(8'h12, 1'b1);
    push(EV_WR, 16'h12A5);
    put_byte(8'hA5, 1'b1);
    check("busy_before_stop", int'(busy), 1);
    bus_stop();
    check("wr_busy_after_stop", int'(busy), 0);
    check("wr_reg_addr", int'(reg_addr), 8'h12);
    check("wr_reg_wdata", int'(reg_wdata), 8'hA5);
    check("wr_drive_cycles", en_cnt - c0, ACK_ON ? 1200 : 0);

    // Two-phase read: set sub-address 0x3A, then read it
    bus_start();
    put_byte(8'h42, 1'b1);
    put_byte(8'h3A, 1'b1);
    bus_stop();
    check("rd_ph1_busy", int'(busy), 0);
    check("rd_ph1_reg_addr", int'(reg_addr), 8'h3A);
    c0 = en_cnt;
    bus_start();
    push(EV_RD, 8'h3A);
    put_byte(8'h43, 1'b1);
    get_byte(8, rb);
    obs_rbyte = rb;
    push(EV_RBYTE, 8'h5C);
    ->rbyte_ev;
    get_bit(b);
    check("na_released", int'(smp_en), 0);
    check("na_level", int'(b), 1);
    bus_stop();
    check("rd_drive_cycles", en_cnt - c0, ACK_ON ? 3600 : 3200);
    check("rd_busy_after_stop", int'(busy), 0);

    // Foreign ID followed by a full write: ignored
    c0 = en_cnt;
    bus_start();
    put_byte(8'h60, 1'b0);
    put_byte(8'h12, 1'b0);
    put_byte(8'hA5, 1'b0);
    bus_stop();
    check("bad_id_drive_cycles", en_cnt - c0, 0);
    check("bad_id_busy", int'(busy), 0);
    check("bad_id_reg_addr", int'(reg_addr), 8'h3A);

    // STOP after 4 sub-address bits
    bus_start();
    put_byte(8'h42, 1'b1);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    push(EV_ERR, 0);
    bus_stop();
    check("short_sub_busy", int'(busy), 0);
    check("short_sub_reg_addr", int'(reg_addr), 8'h3A);

    // Reset while the responder drives read-data bit 3
    bus_start();
    push(EV_RD, 8'h3A);
    put_byte(8'h43, 1'b1);
    get_byte(4, rb);
    check("rd_nibble", int'(rb), 8'h05);
    check("bit3_driving", int'(sio_out_en), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_sio_out_en", int'(sio_out_en), 0);
    check("midrst_sio_out", int'(sio_out), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_reg_addr", int'(reg_addr), 0);
    wait_clk(2);
    sclk = 1'b1; m_sio = 1'b1;
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(20);

    // Full write after the reset
    bus_start();
    put_byte(8'h42, 1'b1);
    put_byte(8'h07, 1'b1);
    push(EV_WR, 16'h073C);
    put_byte(8'h3C, 1'b1);
    bus_stop();
    check("post_rst_reg_addr", int'(reg_addr), 8'h07);
    check("post_rst_reg_wdata", int'(reg_wdata), 8'h3C);
    check("post_rst_busy", int'(busy), 0);

    wait_clk(10);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
